// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Integer execution unit fed by the reservation-station issue port. Each
//   issued op (R-type, I-arith or branch compare) is evaluated in the issue
//   cycle. The {rob_id, value} pair is queued in a small result FIFO, and the
//   FIFO head is presented on the ALU lane of the CDB.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   rdy_in                global ready; low freezes all state
//   _clear                synchronous pipeline flush (needs rdy_in)
//   _alu_ready            issue valid
//   _alu_rob_id/_type/_op issue tag, opcode, {funct7[5], funct3}
//   _alu_v1/_alu_v2       operands (v2 is the immediate for I-arith)
//   _alu_full             count >= DEPTH-1, sampled by the reservation station
//   _cdb_grant            CDB arbiter accepts the current head
//   _cdb_ready/_rob_id/_value  FIFO head on the CDB
//   _alu_overflow         sticky: an issue was dropped because the FIFO was full
module alu_exec_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _alu_ready,
    input  logic [4:0]  _alu_rob_id,
    input  logic [6:0]  _alu_type,
    input  logic [3:0]  _alu_op,
    input  logic [31:0] _alu_v1,
    input  logic [31:0] _alu_v2,
    output logic        _alu_full,
    input  logic        _cdb_grant,
    output logic        _cdb_ready,
    output logic [4:0]  _cdb_rob_id,
    output logic [31:0] _cdb_value,
    output logic        _alu_overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_MARK = CW'(DEPTH - 1);

    localparam logic [6:0] TYPE_R = 7'b0110011;
    localparam logic [6:0] TYPE_I = 7'b0010011;
    localparam logic [6:0] TYPE_B = 7'b1100011;

    // ---------------- compute ----------------
    logic [2:0]  funct3;
    logic [3:0]  eff_op;
    logic [4:0]  shamt;
    logic [31:0] arith_res;
    logic        br_taken;
    logic [31:0] alu_value;

    always_comb begin
        funct3    = _alu_op[2:0];
        shamt     = _alu_v2[4:0];
        // For I-arith the funct7 bit only selects SRAI; elsewhere it is part
        // of the immediate and must not turn ADDI into SUB.
        eff_op    = (_alu_type == TYPE_I && funct3 != 3'b101) ? {1'b0, funct3} : _alu_op;
        arith_res = '0;
        case (eff_op)
            4'b0000: arith_res = _alu_v1 + _alu_v2;
            4'b1000: arith_res = _alu_v1 - _alu_v2;
            4'b0001: arith_res = _alu_v1 << shamt;
            4'b0010: arith_res = {31'b0, $signed(_alu_v1) < $signed(_alu_v2)};
            4'b0011: arith_res = {31'b0, _alu_v1 < _alu_v2};
            4'b0100: arith_res = _alu_v1 ^ _alu_v2;
            4'b0101: arith_res = _alu_v1 >> shamt;
            4'b1101: arith_res = 32'($signed(_alu_v1) >>> shamt);
            4'b0110: arith_res = _alu_v1 | _alu_v2;
            4'b0111: arith_res = _alu_v1 & _alu_v2;
            default: arith_res = '0;
        endcase

        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (_alu_v1 == _alu_v2);
            3'b001:  br_taken = (_alu_v1 != _alu_v2);
            3'b100:  br_taken = ($signed(_alu_v1) <  $signed(_alu_v2));
            3'b101:  br_taken = ($signed(_alu_v1) >= $signed(_alu_v2));
            3'b110:  br_taken = (_alu_v1 <  _alu_v2);
            3'b111:  br_taken = (_alu_v1 >= _alu_v2);
            default: br_taken = 1'b0;
        endcase

        alu_value = '0;
        case (_alu_type)
            TYPE_R, TYPE_I: alu_value = arith_res;
            TYPE_B:         alu_value = {31'b0, br_taken};
            default:        alu_value = '0;
        endcase
    end

    // ---------------- result FIFO ----------------
    logic [4:0]    rob_mem_q [DEPTH];
    logic [4:0]    rob_mem_d [DEPTH];
    logic [31:0]   val_mem_q [DEPTH];
    logic [31:0]   val_mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          do_pop, do_push, drop_issue;

    always_comb begin
        do_pop     = rdy_in && !_clear && (count_q != '0) && _cdb_grant;
        // A full FIFO still accepts an issue when the head leaves this cycle.
        do_push    = rdy_in && !_clear && _alu_ready && ((count_q != DEPTH_C) || do_pop);
        drop_issue = rdy_in && !_clear && _alu_ready && (count_q == DEPTH_C) && !do_pop;

        rob_mem_d  = rob_mem_q;
        val_mem_d  = val_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (rdy_in && _clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                rob_mem_d[wr_ptr_q] = _alu_rob_id;
                val_mem_d[wr_ptr_q] = alu_value;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (drop_issue) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Storage is reset too so the CDB fields read zero out of reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rob_mem_q[i] <= '0;
                val_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rob_mem_q  <= rob_mem_d;
            val_mem_q  <= val_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign _alu_full     = (count_q >= FULL_MARK);
    assign _cdb_ready    = (count_q != '0);
    assign _cdb_rob_id   = rob_mem_q[rd_ptr_q];
    assign _cdb_value    = val_mem_q[rd_ptr_q];
    assign _alu_overflow = overflow_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Directed scenarios followed by randomized traffic on alu_exec_unit,
//   compared against a queue-based reference model of the result FIFO and a
//   plain-arithmetic model of the ALU.
module tb_alu_exec_unit;

    localparam int DEPTH = 4;
    localparam logic [6:0] T_R = 7'b0110011;
    localparam logic [6:0] T_I = 7'b0010011;
    localparam logic [6:0] T_B = 7'b1100011;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [6:0]  _alu_type;
    logic [3:0]  _alu_op;
    logic [31:0] _alu_v1;
    logic [31:0] _alu_v2;
    logic        _alu_full;
    logic        _cdb_grant;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;
    logic        _alu_overflow;

    alu_exec_unit #(.DEPTH(DEPTH)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        ._clear        (_clear),
        ._alu_ready    (_alu_ready),
        ._alu_rob_id   (_alu_rob_id),
        ._alu_type     (_alu_type),
        ._alu_op       (_alu_op),
        ._alu_v1       (_alu_v1),
        ._alu_v2       (_alu_v2),
        ._alu_full     (_alu_full),
        ._cdb_grant    (_cdb_grant),
        ._cdb_ready    (_cdb_ready),
        ._cdb_rob_id   (_cdb_rob_id),
        ._cdb_value    (_cdb_value),
        ._alu_overflow (_alu_overflow)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  rob;
        logic [31:0] val;
    } ent_t;

    ent_t mq[$];
    bit   movf;

    function automatic logic [31:0] ref_alu(input logic [6:0] t, input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [2:0] f3;
        logic [4:0] sh;
        bit         alt;
        f3  = op[2:0];
        sh  = b[4:0];
        alt = op[3];
        if (t == T_R || t == T_I) begin
            if (t == T_I && f3 != 3'd5) alt = 0;
            if (alt && f3 != 3'd0 && f3 != 3'd5) return 32'd0;
            case (f3)
                3'd0: return alt ? a - b : a + b;
                3'd1: return a << sh;
                3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        if (t == T_B) begin
            case (f3)
                3'd0: return (a == b) ? 32'd1 : 32'd0;
                3'd1: return (a != b) ? 32'd1 : 32'd0;
                3'd4: return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
                3'd5: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
                3'd6: return (a <  b) ? 32'd1 : 32'd0;
                3'd7: return (a >= b) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic model_edge();
        bit pop;
        if (!rdy_in) return;
        if (_clear) begin
            mq.delete();
            return;
        end
        pop = _cdb_grant && (mq.size() != 0);
        if (pop) void'(mq.pop_front());
        if (_alu_ready) begin
            if (mq.size() < DEPTH)
                mq.push_back(ent_t'{rob: _alu_rob_id,
                                    val: ref_alu(_alu_type, _alu_op, _alu_v1, _alu_v2)});
            else
                movf = 1;
        end
    endtask

    task automatic compare_model();
        check("cdb_ready", 32'(_cdb_ready), 32'(mq.size() != 0));
        check("alu_full", 32'(_alu_full), 32'(mq.size() >= DEPTH - 1));
        check("overflow", 32'(_alu_overflow), 32'(movf));
        if (mq.size() != 0) begin
            check("head_rob", 32'(_cdb_rob_id), 32'(mq[0].rob));
            check("head_val", _cdb_value, mq[0].val);
        end
    endtask

    // One clock: inputs already driven; model follows the edge, outputs
    // are sampled 1 time unit later.
    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle();
        rdy_in = 1; _clear = 0; _alu_ready = 0; _cdb_grant = 0;
    endtask

    task automatic issue(input logic [4:0] tag, input logic [6:0] t, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        _alu_ready = 1; _alu_rob_id = tag; _alu_type = t; _alu_op = op;
        _alu_v1 = a; _alu_v2 = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(_cdb_ready), 32'd0);
        check({tag, "_rob"}, 32'(_cdb_rob_id), 32'd0);
        check({tag, "_val"}, _cdb_value, 32'd0);
        check({tag, "_ovf"}, 32'(_alu_overflow), 32'd0);
        check({tag, "_full"}, 32'(_alu_full), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1;
        #1;
        mq.delete();
        movf = 0;
        check_all_zero("reset");
        @(negedge clk_in);
        rst_in = 0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_in = 1; idle();
        _alu_rob_id = '0; _alu_type = '0; _alu_op = '0; _alu_v1 = '0; _alu_v2 = '0;
        #1;
        check_all_zero("por");
        @(negedge clk_in);
        rst_in = 0;

        // Mid-cycle reset with three entries queued.
        for (int i = 1; i <= 3; i++) begin
            issue(5'(i + 10), T_R, 4'b0000, 32'(i), 32'd1);
            step();
        end
        idle();
        check("pre_reset_rob", 32'(_cdb_rob_id), 32'd11);
        do_reset();

        // R-type with grant held.
        idle(); _cdb_grant = 1;
        issue(5'd3, T_R, 4'b1000, 32'd5, 32'd7);
        step();
        check("sub_val", _cdb_value, 32'hFFFFFFFE);
        check("sub_rob", 32'(_cdb_rob_id), 32'd3);
        issue(5'd4, T_R, 4'b1101, 32'h80000000, 32'd4);
        step();
        check("sra_val", _cdb_value, 32'hF8000000);
        issue(5'd5, T_B, 4'b0100, 32'hFFFFFFFF, 32'd1);
        step();
        check("blt_val", _cdb_value, 32'd1);
        issue(5'd6, T_B, 4'b0110, 32'hFFFFFFFF, 32'd1);
        step();
        check("bltu_val", _cdb_value, 32'd0);
        issue(5'd7, T_I, 4'b1000, 32'd5, 32'd7);
        step();
        check("addi_alt", _cdb_value, 32'd12);
        idle(); _cdb_grant = 1;
        step();
        check("drained", 32'(_cdb_ready), 32'd0);

        // Back-pressure and overflow.
        idle();
        for (int i = 1; i <= 3; i++) begin
            issue(5'(i), T_R, 4'b0000, 32'(i), 32'd0);
            step();
        end
        check("full_at_3", 32'(_alu_full), 32'd1);
        issue(5'd4, T_R, 4'b0000, 32'd4, 32'd0);
        step();
        issue(5'd5, T_R, 4'b0000, 32'd5, 32'd0);
        step();
        check("ovf_set", 32'(_alu_overflow), 32'd1);
        check("head_tag1", 32'(_cdb_rob_id), 32'd1);
        idle(); _cdb_grant = 1;
        for (int i = 2; i <= 4; i++) begin
            step();
            check("order", 32'(_cdb_rob_id), 32'(i));
        end
        step();
        check("empty_after", 32'(_cdb_ready), 32'd0);

        // Push + pop while full.
        do_reset();
        idle();
        for (int i = 1; i <= 4; i++) begin
            issue(5'(i + 20), T_R, 4'b0100, 32'(i), 32'hF0);
            step();
        end
        issue(5'd25, T_R, 4'b0000, 32'd9, 32'd9);
        _cdb_grant = 1;
        step();
        check("pp_full", 32'(_alu_full), 32'd1);
        check("pp_noovf", 32'(_alu_overflow), 32'd0);
        check("pp_head", 32'(_cdb_rob_id), 32'd22);
        idle(); _cdb_grant = 1;
        for (int i = 0; i < 4; i++) step();
        check("pp_drained", 32'(_cdb_ready), 32'd0);

        // Clear with a same-cycle issue, then a frozen period.
        idle();
        issue(5'd8, T_R, 4'b0000, 32'd1, 32'd1); step();
        issue(5'd9, T_R, 4'b0000, 32'd2, 32'd1); step();
        issue(5'd10, T_R, 4'b0000, 32'd3, 32'd1);
        _clear = 1; _cdb_grant = 1;
        step();
        check("clr_ready", 32'(_cdb_ready), 32'd0);
        idle();
        step();
        check("clr_lost", 32'(_cdb_ready), 32'd0);
        issue(5'd12, T_R, 4'b0110, 32'h0F, 32'hF0); step();
        issue(5'd13, T_R, 4'b0000, 32'd0, 32'd0);
        rdy_in = 0; _cdb_grant = 1; _clear = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) _clear = 1;
            step();
        end
        check("frz_rob", 32'(_cdb_rob_id), 32'd12);
        check("frz_val", _cdb_value, 32'hFF);
        idle(); _cdb_grant = 1;
        step();

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rdy_in      = ($urandom_range(0, 9) != 0);
            _clear      = ($urandom_range(0, 39) == 0);
            _alu_ready  = ($urandom_range(0, 3) != 0);
            _cdb_grant  = ($urandom_range(0, 2) == 0);
            _alu_rob_id = 5'($urandom);
            case ($urandom_range(0, 7))
                0, 1, 2: _alu_type = T_R;
                3, 4:    _alu_type = T_I;
                5, 6:    _alu_type = T_B;
                default: _alu_type = 7'($urandom);
            endcase
            _alu_op = 4'($urandom);
            _alu_v1 = pick_operand();
            _alu_v2 = pick_operand();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
